// File: rtl/vending_bank_ctrl.sv
// Multi-machine vending controller: one request port, per-(machine,product) stock,
// shared price table, exact-fund/change modes, sugar checks, restock and sales counters.
module vending_bank_ctrl #(
    parameter int N_VM       = 2,
    parameter int ID_W       = 3,
    parameter int MONEY_W    = 6,
    parameter int STOCK_W    = 5,
    parameter int STOCK_INIT = 10,
    parameter int REV_W      = 16,
    localparam int N_PROD    = 2 ** ID_W,
    localparam int VM_W      = (N_VM > 1) ? $clog2(N_VM) : 1,
    parameter logic [N_PROD*MONEY_W-1:0] PRICE =
        {6'd0, 6'd0, 6'd15, 6'd8, 6'd12, 6'd5, 6'd10, 6'd20},
    parameter logic [N_VM*N_PROD-1:0] VALID_MASK = {8'h3C, 8'h07},
    parameter logic [N_VM-1:0]        EXACT_MASK = 2'b01,
    parameter logic [N_VM-1:0]        SUGAR_VM   = 2'b10,
    parameter logic [N_PROD-1:0]      SUGAR_OK   = 8'h38
) (
    input  logic               CLK,
    input  logic               RSTN,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic [VM_W-1:0]    req_vm,
    input  logic [ID_W-1:0]    req_id,
    input  logic [MONEY_W-1:0] req_money,
    input  logic               req_sugar,
    output logic               rsp_valid,
    output logic [MONEY_W-1:0] money_left,
    output logic [STOCK_W-1:0] item_left,
    output logic               product_ready,
    output logic               invalid_product,
    output logic               product_unavailable,
    output logic               insufficient_fund,
    output logic               not_exact_fund,
    output logic               sugar_unsuitable,
    input  logic               restock_en,
    input  logic [VM_W-1:0]    restock_vm,
    input  logic [ID_W-1:0]    restock_id,
    input  logic [STOCK_W-1:0] restock_qty,
    output logic [REV_W-1:0]   sales_count,
    output logic [REV_W-1:0]   revenue
);

    typedef enum logic [1:0] {IDLE, EVAL, RESP} stateT;

    stateT state, stateNext;

    logic [MONEY_W-1:0] priceTab [N_PROD];
    logic [N_PROD-1:0]  soldRow  [N_VM];

    for (genvar p = 0; p < N_PROD; p++) begin : gPrice
        assign priceTab[p] = PRICE[p*MONEY_W +: MONEY_W];
    end
    for (genvar v = 0; v < N_VM; v++) begin : gSold
        assign soldRow[v] = VALID_MASK[v*N_PROD +: N_PROD];
    end

    logic [VM_W-1:0]    reqVm;
    logic [ID_W-1:0]    reqId;
    logic [MONEY_W-1:0] reqMoney;
    logic               reqSugar;

    logic [STOCK_W-1:0] stock     [N_VM][N_PROD];
    logic [STOCK_W-1:0] stockNext [N_VM][N_PROD];

    logic               vmInRange, restockVmOk, sold, exactVm;
    logic [VM_W-1:0]    vmIdx;
    logic [STOCK_W-1:0] curStock;
    logic [MONEY_W-1:0] price;
    logic               flagInvalid, flagUnavail, flagInsuf, flagNotExact, flagSugar, okAll;
    logic               dispense;
    logic [REV_W:0]     revSum, salesSum;

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) state <= IDLE;
        else       state <= stateNext;
    end

    always_comb begin
        stateNext = state;
        req_ready = (state == IDLE);
        case (state)
            IDLE:    if (req_valid) stateNext = EVAL;
            EVAL:    stateNext = RESP;
            RESP:    stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    always_comb begin
        vmInRange    = (32'(reqVm) < N_VM);
        vmIdx        = vmInRange ? reqVm : '0;
        sold         = vmInRange && soldRow[vmIdx][reqId];
        curStock     = stock[vmIdx][reqId];
        price        = priceTab[reqId];
        exactVm      = EXACT_MASK[vmIdx];
        flagInvalid  = 1'b0;
        flagUnavail  = 1'b0;
        flagInsuf    = 1'b0;
        flagNotExact = 1'b0;
        flagSugar    = 1'b0;
        okAll        = 1'b0;
        // first matching error wins; success only when no check fires
        if (!sold)                                          flagInvalid  = 1'b1;
        else if (curStock == '0)                            flagUnavail  = 1'b1;
        else if (exactVm && (reqMoney != price))            flagNotExact = 1'b1;
        else if (!exactVm && (reqMoney < price))            flagInsuf    = 1'b1;
        else if (SUGAR_VM[vmIdx] && reqSugar && !SUGAR_OK[reqId]) flagSugar = 1'b1;
        else                                                okAll        = 1'b1;
        dispense = (state == EVAL) && okAll;
        revSum   = {1'b0, revenue} + (REV_W+1)'(price);
        salesSum = {1'b0, sales_count} + (REV_W+1)'(1);
    end

    // Dispense and restock may hit the same slot on one edge; the carry bit flags saturation.
    always_comb begin
        restockVmOk = (32'(restock_vm) < N_VM);
        for (int unsigned v = 0; v < N_VM; v++) begin
            for (int unsigned p = 0; p < N_PROD; p++) begin
                logic [STOCK_W:0] sum;
                sum = {1'b0, stock[v][p]};
                if (dispense && (vmIdx == VM_W'(v)) && (reqId == ID_W'(p)))
                    sum = sum - (STOCK_W+1)'(1);
                if (restock_en && restockVmOk && soldRow[v][p] &&
                    (restock_vm == VM_W'(v)) && (restock_id == ID_W'(p)))
                    sum = sum + {1'b0, restock_qty};
                stockNext[v][p] = sum[STOCK_W] ? '1 : sum[STOCK_W-1:0];
            end
        end
    end

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            reqVm               <= '0;
            reqId               <= '0;
            reqMoney            <= '0;
            reqSugar            <= 1'b0;
            rsp_valid           <= 1'b0;
            money_left          <= '0;
            item_left           <= '0;
            product_ready       <= 1'b0;
            invalid_product     <= 1'b0;
            product_unavailable <= 1'b0;
            insufficient_fund   <= 1'b0;
            not_exact_fund      <= 1'b0;
            sugar_unsuitable    <= 1'b0;
            sales_count         <= '0;
            revenue             <= '0;
            for (int unsigned v = 0; v < N_VM; v++)
                for (int unsigned p = 0; p < N_PROD; p++)
                    stock[v][p] <= soldRow[v][p] ? STOCK_W'(STOCK_INIT) : '0;
        end else begin
            if (req_valid && req_ready) begin
                reqVm    <= req_vm;
                reqId    <= req_id;
                reqMoney <= req_money;
                reqSugar <= req_sugar;
            end
            for (int unsigned v = 0; v < N_VM; v++)
                for (int unsigned p = 0; p < N_PROD; p++)
                    stock[v][p] <= stockNext[v][p];
            if (state == EVAL) begin
                rsp_valid           <= 1'b1;
                product_ready       <= okAll;
                invalid_product     <= flagInvalid;
                product_unavailable <= flagUnavail;
                insufficient_fund   <= flagInsuf;
                not_exact_fund      <= flagNotExact;
                sugar_unsuitable    <= flagSugar;
                if (okAll) begin
                    money_left  <= exactVm ? '0 : reqMoney - price;
                    item_left   <= stockNext[vmIdx][reqId];
                    sales_count <= salesSum[REV_W] ? '1 : salesSum[REV_W-1:0];
                    revenue     <= revSum[REV_W] ? '1 : revSum[REV_W-1:0];
                end else begin
                    money_left <= reqMoney;
                    item_left  <= sold ? curStock : '0;
                end
            end else begin
                rsp_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_vending_bank_ctrl.sv
// Directed bench for vending_bank_ctrl: expected responses come from a small reference
// model, are queued at request time and checked when rsp_valid pulses.
module tb_vending_bank_ctrl;

    logic       CLK = 1'b0;
    logic       RSTN = 1'b0;
    logic       req_valid = 1'b0;
    logic       req_ready;
    logic [0:0] req_vm = '0;
    logic [2:0] req_id = '0;
    logic [5:0] req_money = '0;
    logic       req_sugar = 1'b0;
    logic       rsp_valid;
    logic [5:0] money_left;
    logic [4:0] item_left;
    logic       product_ready, invalid_product, product_unavailable;
    logic       insufficient_fund, not_exact_fund, sugar_unsuitable;
    logic       restock_en = 1'b0;
    logic [0:0] restock_vm = '0;
    logic [2:0] restock_id = '0;
    logic [4:0] restock_qty = '0;
    logic [15:0] sales_count, revenue;

    vending_bank_ctrl dut (
        .CLK(CLK), .RSTN(RSTN),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_vm(req_vm), .req_id(req_id), .req_money(req_money), .req_sugar(req_sugar),
        .rsp_valid(rsp_valid), .money_left(money_left), .item_left(item_left),
        .product_ready(product_ready), .invalid_product(invalid_product),
        .product_unavailable(product_unavailable), .insufficient_fund(insufficient_fund),
        .not_exact_fund(not_exact_fund), .sugar_unsuitable(sugar_unsuitable),
        .restock_en(restock_en), .restock_vm(restock_vm), .restock_id(restock_id),
        .restock_qty(restock_qty), .sales_count(sales_count), .revenue(revenue)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic       ok, inv, unav, insuf, nexact, sugar;
        logic [5:0] money;
        logic [4:0] item;
    } expT;

    expT sbq[$];
    int total = 0;
    int bad = 0;

    int       mStock [2][8];
    int       mSales, mRev;
    int       priceT [8]  = '{20, 10, 5, 12, 8, 15, 0, 0};
    bit [7:0] soldM  [2]  = '{8'h07, 8'h3C};
    bit       exactM [2]  = '{1'b1, 1'b0};
    bit       sugarVmM [2] = '{1'b0, 1'b1};
    bit [7:0] sugarOkM    = 8'h38;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    task automatic modelReset();
        for (int v = 0; v < 2; v++)
            for (int p = 0; p < 8; p++)
                mStock[v][p] = soldM[v][p] ? 10 : 0;
        mSales = 0;
        mRev   = 0;
    endtask

    task automatic addStock(input int vm, input int id, input int qty);
        if (soldM[vm][id]) begin
            mStock[vm][id] = mStock[vm][id] + qty;
            if (mStock[vm][id] > 31) mStock[vm][id] = 31;
        end
    endtask

    task automatic restock(input int vm, input int id, input int qty);
        @(negedge CLK);
        restock_en  = 1'b1;
        restock_vm  = 1'(vm);
        restock_id  = 3'(id);
        restock_qty = 5'(qty);
        @(negedge CLK);
        restock_en = 1'b0;
        addStock(vm, id, qty);
    endtask

    // rqty != 0 applies a restock of the same slot on the evaluation edge;
    // hold keeps req_valid asserted until the controller is idle again.
    task automatic doReq(input int vm, input int id, input int money, input int sugar,
                         input int rqty, input int hold, input string tag);
        expT e, got;
        int  pre, lat;
        pre = mStock[vm][id];
        e = '{default: '0};
        e.money = 6'(money);
        e.item  = soldM[vm][id] ? 5'(pre) : 5'd0;
        if (!soldM[vm][id])                              e.inv = 1'b1;
        else if (pre == 0)                               e.unav = 1'b1;
        else if (exactM[vm] && money != priceT[id])      e.nexact = 1'b1;
        else if (!exactM[vm] && money < priceT[id])      e.insuf = 1'b1;
        else if (sugarVmM[vm] && sugar != 0 && !sugarOkM[id]) e.sugar = 1'b1;
        else begin
            e.ok    = 1'b1;
            e.money = exactM[vm] ? 6'd0 : 6'(money - priceT[id]);
            mStock[vm][id] = pre - 1;
            mSales = (mSales < 65535) ? mSales + 1 : 65535;
            mRev   = (mRev + priceT[id] > 65535) ? 65535 : mRev + priceT[id];
        end
        if (rqty != 0) addStock(vm, id, rqty);
        if (e.ok) e.item = 5'(mStock[vm][id]);
        sbq.push_back(e);

        @(negedge CLK);
        req_valid = 1'b1;
        req_vm    = 1'(vm);
        req_id    = 3'(id);
        req_money = 6'(money);
        req_sugar = 1'(sugar);
        lat = 0;
        while (!req_ready && lat < 20) begin
            @(negedge CLK);
            lat++;
        end
        chk({tag, "/ready"}, 32'(req_ready), 1);
        @(negedge CLK);
        if (hold != 0) chk({tag, "/readyEval"}, 32'(req_ready), 0);
        else req_valid = 1'b0;
        if (rqty != 0) begin
            restock_en  = 1'b1;
            restock_vm  = 1'(vm);
            restock_id  = 3'(id);
            restock_qty = 5'(rqty);
        end
        lat = 0;
        do begin
            @(negedge CLK);
            lat++;
            restock_en = 1'b0;
        end while (!rsp_valid && lat < 10);
        chk({tag, "/rspValid"}, 32'(rsp_valid), 1);
        chk({tag, "/latency"}, lat, 1);
        got = sbq.pop_front();
        chk({tag, "/productReady"}, 32'(product_ready), 32'(got.ok));
        chk({tag, "/invalid"}, 32'(invalid_product), 32'(got.inv));
        chk({tag, "/unavail"}, 32'(product_unavailable), 32'(got.unav));
        chk({tag, "/insuf"}, 32'(insufficient_fund), 32'(got.insuf));
        chk({tag, "/notExact"}, 32'(not_exact_fund), 32'(got.nexact));
        chk({tag, "/sugar"}, 32'(sugar_unsuitable), 32'(got.sugar));
        chk({tag, "/moneyLeft"}, 32'(money_left), 32'(got.money));
        chk({tag, "/itemLeft"}, 32'(item_left), 32'(got.item));
        chk({tag, "/sales"}, 32'(sales_count), mSales);
        chk({tag, "/revenue"}, 32'(revenue), mRev);
        if (hold != 0) chk({tag, "/readyResp"}, 32'(req_ready), 0);
        @(negedge CLK);
        req_valid = 1'b0;
        chk({tag, "/rspPulse"}, 32'(rsp_valid), 0);
        chk({tag, "/readyIdle"}, 32'(req_ready), 1);
        chk({tag, "/holdMoney"}, 32'(money_left), 32'(got.money));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        modelReset();
        repeat (2) @(negedge CLK);
        chk("rst/ready", 32'(req_ready), 1);
        chk("rst/rspValid", 32'(rsp_valid), 0);
        chk("rst/productReady", 32'(product_ready), 0);
        chk("rst/moneyLeft", 32'(money_left), 0);
        chk("rst/itemLeft", 32'(item_left), 0);
        chk("rst/sales", 32'(sales_count), 0);
        chk("rst/revenue", 32'(revenue), 0);
        RSTN = 1'b1;

        doReq(0, 0, 20, 0, 0, 0, "vm0id0");
        chk("vm0id0/rev20", 32'(revenue), 20);
        doReq(1, 2, 10, 0, 0, 0, "vm1id2change");
        doReq(1, 4, 12, 0, 0, 0, "vm1id4change");
        doReq(1, 2, 20, 1, 0, 0, "sugarBad");
        doReq(0, 0, 22, 0, 0, 0, "notExact");
        doReq(0, 7, 5, 0, 0, 0, "invalid");
        doReq(1, 2, 1, 0, 0, 0, "insuf");
        doReq(0, 2, 5, 1, 0, 0, "vm0sugarIgnored");
        doReq(1, 3, 12, 1, 0, 0, "sugarOk");
        doReq(0, 4, 8, 0, 0, 0, "vm0notSold");

        doReq(1, 5, 15, 0, 3, 0, "sameEdge");
        doReq(1, 5, 1, 0, 0, 0, "afterSameEdge");

        for (int i = 0; i < 9; i++) doReq(0, 0, 20, 0, 0, 0, "drain");
        doReq(0, 0, 20, 0, 0, 0, "empty");
        restock(0, 0, 31);
        doReq(0, 0, 0, 0, 0, 0, "restock31");
        restock(0, 0, 5);
        doReq(0, 0, 0, 0, 0, 0, "restockSat");
        restock(0, 7, 5);
        doReq(0, 7, 0, 0, 0, 0, "restockInvalid");

        doReq(1, 3, 20, 0, 0, 1, "holdValid");
        repeat (3) begin
            @(negedge CLK);
            chk("holdValid/noSecond", 32'(rsp_valid), 0);
        end

        @(negedge CLK);
        req_valid = 1'b1;
        req_vm    = 1'b0;
        req_id    = 3'd1;
        req_money = 6'd10;
        @(negedge CLK);
        req_valid = 1'b0;
        chk("midRst/inEval", 32'(req_ready), 0);
        RSTN = 1'b0;
        #1;
        chk("midRst/rspValid", 32'(rsp_valid), 0);
        chk("midRst/ready", 32'(req_ready), 1);
        chk("midRst/sales", 32'(sales_count), 0);
        chk("midRst/revenue", 32'(revenue), 0);
        chk("midRst/itemLeft", 32'(item_left), 0);
        @(negedge CLK);
        RSTN = 1'b1;
        modelReset();
        repeat (3) begin
            @(negedge CLK);
            chk("midRst/noRsp", 32'(rsp_valid), 0);
        end
        doReq(0, 1, 10, 0, 0, 0, "postRst");
        doReq(0, 0, 20, 0, 0, 0, "postRstStock");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
